// File: rtl/dig_arbiter_if.sv
// dig_arbiter_if: bundle between the three display sources and the arbiter.
//   req[2:0]     per-source request, held with data stable until its gnt bit
//   data0..2     32-bit display values (nibble 0 = rightmost digit)
//   gnt[2:0]     one-hot grant pulse from the arbiter
//   dig_we       display write strobe (high exactly when gnt != 0)
//   dig_wdata    display write data, held between strobes
//   owner[1:0]   owner index during HOLD, 2'b11 when idle
//   busy         high while a value is being held on screen
// master = source/driver side, slave = arbiter side.
interface dig_arbiter_if;
  logic [2:0]  req;
  logic [31:0] data0;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  gnt;
  logic        dig_we;
  logic [31:0] dig_wdata;
  logic [1:0]  owner;
  logic        busy;

  modport master (
    output req, data0, data1, data2,
    input  gnt, dig_we, dig_wdata, owner, busy
  );

  modport slave (
    input  req, data0, data1, data2,
    output gnt, dig_we, dig_wdata, owner, busy
  );
endinterface

// File: rtl/dig_arbiter.sv
// dig_arbiter: shares the 8-digit seven-segment display driver between
// CPU MMIO (req 0), PC/debug monitor (req 1) and switch-echo (req 2).
// Each granted value owns the display for at least HOLD_CYCLES cycles;
// grants rotate round-robin on hold expiry, an owner may refresh its own
// value, and with PREEMPT=1 source 0 may take over another owner's hold.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  dig_arbiter_if.slave (req/data0..2 in; gnt/dig_we/dig_wdata/owner/busy out)
module dig_arbiter #(
  parameter int unsigned HOLD_CYCLES = 10000000,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned PREEMPT     = 1
) (
  input logic         clk,
  input logic         rst,
  dig_arbiter_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        rr_q, rr_d;

  logic [2:0]        ureq;
  logic              rr_valid;
  logic [1:0]        rr_idx;
  logic [1:0]        c1, c2, c3;
  logic              do_grant;
  logic [1:0]        gidx;

  function automatic logic [1:0] nxt(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // A source is ignored in the cycle its grant pulse is visible, so a
  // requester that keeps req high sees it treated as a fresh request.
  assign ureq = bus.req & ~gnt_q;

  always_comb begin
    c1       = nxt(rr_q);
    c2       = nxt(c1);
    c3       = nxt(c2);
    rr_valid = 1'b0;
    rr_idx   = 2'd0;
    if (ureq[c1]) begin
      rr_valid = 1'b1;
      rr_idx   = c1;
    end else if (ureq[c2]) begin
      rr_valid = 1'b1;
      rr_idx   = c2;
    end else if (ureq[c3]) begin
      rr_valid = 1'b1;
      rr_idx   = c3;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = '0;
    we_d     = 1'b0;
    wdata_d  = wdata_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    rr_d     = rr_q;
    do_grant = 1'b0;
    gidx     = 2'd0;

    unique case (state_q)
      IDLE: begin
        if (rr_valid) begin
          do_grant = 1'b1;
          gidx     = rr_idx;
        end
      end
      HOLD: begin
        if (PREEMPT != 0 && ureq[0] && owner_q != 2'd0) begin
          do_grant = 1'b1;
          gidx     = 2'd0;
        end else if (ureq[owner_q]) begin
          do_grant = 1'b1;
          gidx     = owner_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rr_valid) begin
          do_grant = 1'b1;
          gidx     = rr_idx;
        end else begin
          state_d = IDLE;
          owner_d = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_grant) begin
      gnt_d   = 3'b001 << gidx;
      we_d    = 1'b1;
      owner_d = gidx;
      cnt_d   = CNT_W'(HOLD_CYCLES - 1);
      rr_d    = gidx;
      state_d = HOLD;
      unique case (gidx)
        2'd0:    wdata_d = bus.data0;
        2'd1:    wdata_d = bus.data1;
        default: wdata_d = bus.data2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      owner_q <= 2'b11;
      cnt_q   <= '0;
      rr_q    <= 2'd2;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.dig_we    = we_q;
  assign bus.dig_wdata = wdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q == HOLD);

endmodule

// File: tb/tb_dig_arbiter.sv
// Testbench for dig_arbiter: three instances (A: HOLD=4 PREEMPT=1,
// B: HOLD=4 PREEMPT=0, C: HOLD=1 PREEMPT=1) share stimulus; sel routes
// req to one instance and picks which outputs are observed.
module tb_dig_arbiter;

  localparam logic [31:0] K1 = 32'h12345678;
  localparam logic [31:0] CF = 32'h0000CAFE;
  localparam logic [31:0] A1 = 32'hAAAA0001;
  localparam logic [31:0] B2 = 32'hBBBB0002;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [31:0] d0;
    logic [2:0]  gnt;
    logic        we;
    logic [31:0] wd;
    logic [1:0]  own;
    logic        busy;
  } vec_t;

  typedef struct {
    logic [2:0]  gnt;
    logic        we;
    logic [31:0] wd;
    logic [1:0]  own;
    logic        busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = '0;
  logic [31:0] d0  = K1;
  int unsigned sel = 0;

  int checks   = 0;
  int failures = 0;

  exp_t sb[$];
  vec_t ta[$];
  vec_t tb[$];

  logic [2:0]  o_gnt;
  logic        o_we;
  logic [31:0] o_wd;
  logic [1:0]  o_own;
  logic        o_busy;

  always #5 clk = ~clk;

  dig_arbiter_if ia ();
  dig_arbiter_if ib ();
  dig_arbiter_if ic ();

  assign ia.req = (sel == 0) ? req : 3'b000;
  assign ib.req = (sel == 1) ? req : 3'b000;
  assign ic.req = (sel == 2) ? req : 3'b000;
  assign ia.data0 = d0;  assign ia.data1 = A1;  assign ia.data2 = B2;
  assign ib.data0 = d0;  assign ib.data1 = A1;  assign ib.data2 = B2;
  assign ic.data0 = d0;  assign ic.data1 = A1;  assign ic.data2 = B2;

  dig_arbiter #(.HOLD_CYCLES(4), .CNT_W(8), .PREEMPT(1)) u_a (.clk(clk), .rst(rst), .bus(ia));
  dig_arbiter #(.HOLD_CYCLES(4), .CNT_W(8), .PREEMPT(0)) u_b (.clk(clk), .rst(rst), .bus(ib));
  dig_arbiter #(.HOLD_CYCLES(1), .CNT_W(8), .PREEMPT(1)) u_c (.clk(clk), .rst(rst), .bus(ic));

  always_comb begin
    o_gnt = ia.gnt; o_we = ia.dig_we; o_wd = ia.dig_wdata; o_own = ia.owner; o_busy = ia.busy;
    if (sel == 1) begin
      o_gnt = ib.gnt; o_we = ib.dig_we; o_wd = ib.dig_wdata; o_own = ib.owner; o_busy = ib.busy;
    end else if (sel == 2) begin
      o_gnt = ic.gnt; o_we = ic.dig_we; o_wd = ic.dig_wdata; o_own = ic.owner; o_busy = ic.busy;
    end
  end

  function automatic vec_t mk(input logic r, input logic [2:0] q, input logic [31:0] dd0,
                              input logic [2:0] g, input logic w, input logic [31:0] wd,
                              input logic [1:0] ow, input logic b);
    vec_t v;
    v.rst = r; v.req = q; v.d0 = dd0;
    v.gnt = g; v.we = w; v.wd = wd; v.own = ow; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the clock edge.
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; req = v.req; d0 = v.d0;
    e.gnt = v.gnt; e.we = v.we; e.wd = v.wd; e.own = v.own; e.busy = v.busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".gnt"},   32'(o_gnt),  32'(e.gnt));
      chk({tag, ".we"},    32'(o_we),   32'(e.we));
      chk({tag, ".wdata"}, o_wd,        e.wd);
      chk({tag, ".owner"}, 32'(o_own),  32'(e.own));
      chk({tag, ".busy"},  32'(o_busy), 32'(e.busy));
      chk({tag, ".onehot"}, 32'($onehot0(o_gnt)), 32'd1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] prev_wd;
    int last_we, max_gap, cyc;
    logic seen0, seen1;

    // Table A: HOLD=4, PREEMPT=1
    ta.push_back(mk(1, 3'b000, K1, 3'b000, 0, 0,  3, 0));
    ta.push_back(mk(0, 3'b001, K1, 3'b001, 1, K1, 0, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b000, K1, 3'b000, 0, K1, 0, 1));
    for (int i = 0; i < 2; i++) ta.push_back(mk(0, 3'b000, K1, 3'b000, 0, K1, 3, 0));
    ta.push_back(mk(0, 3'b100, K1, 3'b100, 1, B2, 2, 1));
    ta.push_back(mk(0, 3'b000, K1, 3'b000, 0, B2, 2, 1));
    ta.push_back(mk(0, 3'b001, CF, 3'b001, 1, CF, 0, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, CF, 0, 1));
    ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, CF, 3, 0));
    ta.push_back(mk(1, 3'b111, CF, 3'b000, 0, 0,  3, 0));
    ta.push_back(mk(0, 3'b111, CF, 3'b001, 1, CF, 0, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b110, CF, 3'b000, 0, CF, 0, 1));
    ta.push_back(mk(0, 3'b110, CF, 3'b010, 1, A1, 1, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b100, CF, 3'b000, 0, A1, 1, 1));
    ta.push_back(mk(0, 3'b100, CF, 3'b100, 1, B2, 2, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, B2, 2, 1));
    ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, B2, 3, 0));
    ta.push_back(mk(0, 3'b010, CF, 3'b010, 1, A1, 1, 1));
    ta.push_back(mk(1, 3'b010, CF, 3'b000, 0, 0,  3, 0));
    ta.push_back(mk(0, 3'b010, CF, 3'b010, 1, A1, 1, 1));
    ta.push_back(mk(0, 3'b010, CF, 3'b000, 0, A1, 1, 1));
    ta.push_back(mk(0, 3'b010, CF, 3'b010, 1, A1, 1, 1));
    for (int i = 0; i < 3; i++) ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, A1, 1, 1));
    ta.push_back(mk(0, 3'b000, CF, 3'b000, 0, A1, 3, 0));

    // Table B: HOLD=4, PREEMPT=0
    tb.push_back(mk(1, 3'b000, K1, 3'b000, 0, 0,  3, 0));
    tb.push_back(mk(0, 3'b100, K1, 3'b100, 1, B2, 2, 1));
    tb.push_back(mk(0, 3'b000, K1, 3'b000, 0, B2, 2, 1));
    for (int i = 0; i < 2; i++) tb.push_back(mk(0, 3'b001, CF, 3'b000, 0, B2, 2, 1));
    tb.push_back(mk(0, 3'b001, CF, 3'b001, 1, CF, 0, 1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0, 3'b110, CF, 3'b000, 0, CF, 0, 1));
    tb.push_back(mk(0, 3'b110, CF, 3'b010, 1, A1, 1, 1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0, 3'b100, CF, 3'b000, 0, A1, 1, 1));
    tb.push_back(mk(0, 3'b100, CF, 3'b100, 1, B2, 2, 1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0, 3'b010, CF, 3'b000, 0, B2, 2, 1));
    tb.push_back(mk(0, 3'b010, CF, 3'b010, 1, A1, 1, 1));
    for (int i = 0; i < 3; i++) tb.push_back(mk(0, 3'b000, CF, 3'b000, 0, A1, 1, 1));
    tb.push_back(mk(0, 3'b000, CF, 3'b000, 0, A1, 3, 0));

    sel = 0;
    for (int i = 0; i < ta.size(); i++) step(ta[i], $sformatf("A%0d", i));
    sel = 1;
    for (int i = 0; i < tb.size(); i++) step(tb[i], $sformatf("B%0d", i));

    // C: HOLD=1, req=011 held continuously
    sel = 2;
    step(mk(1, 3'b000, K1, 3'b000, 0, 0, 3, 0), "C_rst");
    prev_wd = '0; last_we = -1; max_gap = 0; seen0 = 0; seen1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = 1'b0; req = 3'b011; d0 = K1;
      @(posedge clk);
      #1;
      cyc = i;
      chk($sformatf("C%0d.onehot", i), 32'($onehot0(o_gnt)), 32'd1);
      chk($sformatf("C%0d.wd_needs_we", i), 32'((o_wd != prev_wd) && !o_we), 32'd0);
      chk($sformatf("C%0d.no_c2", i), 32'(o_gnt[2]), 32'd0);
      if (o_we) begin
        if (last_we >= 0 && (cyc - last_we) > max_gap) max_gap = cyc - last_we;
        last_we = cyc;
        if (o_gnt[0]) begin seen0 = 1; chk($sformatf("C%0d.wd0", i), o_wd, K1); end
        if (o_gnt[1]) begin seen1 = 1; chk($sformatf("C%0d.wd1", i), o_wd, A1); end
      end
      prev_wd = o_wd;
    end
    chk("C.seen0", 32'(seen0), 32'd1);
    chk("C.seen1", 32'(seen1), 32'd1);
    chk("C.max_gap_le2", 32'(max_gap <= 2 && last_we >= 0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
